// File: rtl/snake_body.sv
// snake_body: segment store and move/collision engine for the snake game.
//   clk, rst         rising-edge clock, synchronous active-high reset
//   tick             one-cycle game-step strobe (accepted only while ALIVE)
//   dir              requested heading: 00 up, 01 right, 10 down, 11 left
//   grow             one-cycle apple-eaten strobe, held pending until the next move
//   snake_pos        segment origins, index 0 = head; only masked entries are meaningful
//   mask, length     live-segment mask and count (mask == (1 << length) - 1)
//   busy             high while a move is being scanned or the game is over
//   step_done        one-cycle pulse when a move's self-collision scan finds nothing
//   dead             game-over flag, held until reset

package snakePkg;
  localparam int unsigned COORD_W = 12;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pt2D;
endpackage

module snake_body
  import snakePkg::*;
#(
  parameter int unsigned SNAKE_SIZE = 32,
  parameter int unsigned STEP       = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [1:0]                    dir,
  input  logic                          grow,
  output pt2D  [SNAKE_SIZE-1:0]         snake_pos,
  output logic [SNAKE_SIZE-1:0]         mask,
  output logic [$clog2(SNAKE_SIZE):0]   length,
  output logic                          busy,
  output logic                          step_done,
  output logic                          dead
);

  localparam int unsigned LEN_W    = $clog2(SNAKE_SIZE) + 1;
  localparam int unsigned IDX_W    = $clog2(SNAKE_SIZE);
  localparam int unsigned MASK_W   = SNAKE_SIZE + 1;
  localparam int unsigned CAND_W   = COORD_W + 1;
  localparam int unsigned INIT_LEN = 4;

  localparam logic signed [CAND_W-1:0] STEP_S = CAND_W'(STEP);
  localparam logic signed [CAND_W-1:0] X_MAX  = CAND_W'(800 - STEP);
  localparam logic signed [CAND_W-1:0] Y_MAX  = CAND_W'(600 - STEP);

  typedef enum logic [1:0] {ALIVE, SCAN, DEAD} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                heading_q, heading_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      pending_q, pending_d;
  pt2D  [SNAKE_SIZE-1:0]     pos_d;
  logic [LEN_W-1:0]          len_d;
  logic [SNAKE_SIZE-1:0]     mask_d;
  logic [MASK_W-1:0]         mask_ext;
  logic                      step_done_d;
  logic [1:0]                next_dir;
  logic signed [CAND_W-1:0]  cx, cy;
  logic                      out_of_bounds;
  logic                      hit;
  logic                      scan_last;
  pt2D                       cand;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    heading_d   = heading_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    pos_d       = snake_pos;
    len_d       = length;
    step_done_d = 1'b0;

    // A request for the exact reverse of the current heading is ignored
    next_dir = (dir == (heading_q ^ 2'b10)) ? heading_q : dir;

    // Candidate head in a one-bit-wider signed space so x/y < 0 is detectable
    cx = $signed({1'b0, snake_pos[0].x});
    cy = $signed({1'b0, snake_pos[0].y});
    case (next_dir)
      2'b00:   cy = cy - STEP_S;
      2'b01:   cx = cx + STEP_S;
      2'b10:   cy = cy + STEP_S;
      default: cx = cx - STEP_S;
    endcase
    out_of_bounds = cx[CAND_W-1] || (cx > X_MAX) || cy[CAND_W-1] || (cy > Y_MAX);
    cand.x = COORD_W'(cx);
    cand.y = COORD_W'(cy);

    hit       = (snake_pos[0] == snake_pos[idx_q]);
    scan_last = (LEN_W'(idx_q) == (length - LEN_W'(1)));

    case (state_q)
      ALIVE: begin
        if (grow) pending_d = 1'b1;
        if (tick) begin
          if (out_of_bounds) begin
            state_d = DEAD;
          end else begin
            for (int i = 1; i < SNAKE_SIZE; i++) pos_d[i] = snake_pos[i-1];
            pos_d[0]  = cand;
            heading_d = next_dir;
            // The old tail was just shifted one slot down; growing exposes it
            if (pending_d) begin
              if (length != LEN_W'(SNAKE_SIZE)) len_d = length + LEN_W'(1);
              pending_d = 1'b0;
            end
            idx_d   = IDX_W'(1);
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (grow) pending_d = 1'b1;
        if (hit) begin
          state_d = DEAD;
        end else if (scan_last) begin
          state_d     = ALIVE;
          step_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = ALIVE;
      end
    endcase

    mask_ext = (MASK_W'(1) << len_d) - MASK_W'(1);
    mask_d   = mask_ext[SNAKE_SIZE-1:0];
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ALIVE;
      heading_q <= 2'b01;
      idx_q     <= IDX_W'(1);
      pending_q <= 1'b0;
      length    <= LEN_W'(INIT_LEN);
      mask      <= SNAKE_SIZE'((1 << INIT_LEN) - 1);
      busy      <= 1'b0;
      step_done <= 1'b0;
      dead      <= 1'b0;
      for (int i = 0; i < SNAKE_SIZE; i++) begin
        if (i < INIT_LEN) begin
          snake_pos[i].x <= COORD_W'(400 - STEP * i);
          snake_pos[i].y <= COORD_W'(300);
        end else begin
          snake_pos[i] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      snake_pos <= pos_d;
      length    <= len_d;
      mask      <= mask_d;
      busy      <= (state_d != ALIVE);
      step_done <= step_done_d;
      dead      <= (state_d == DEAD);
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with hand-computed expectations.
module tb_snake_body;

  localparam int unsigned N = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               tick = 1'b0;
  logic [1:0]         dir = 2'b01;
  logic               grow = 1'b0;
  snakePkg::pt2D [N-1:0] snake_pos;
  logic [N-1:0]       mask;
  logic [5:0]         length;
  logic               busy;
  logic               step_done;
  logic               dead;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  bit sd;

  snake_body #(.SNAKE_SIZE(N), .STEP(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .dir       (dir),
    .grow      (grow),
    .snake_pos (snake_pos),
    .mask      (mask),
    .length    (length),
    .busy      (busy),
    .step_done (step_done),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; tick = 1'b0; grow = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Issue one tick, then wait (bounded) for the scan to finish or the snake to die
  task automatic run_tick(input logic [1:0] d, output int scan_cyc, output bit sd_seen);
    @(negedge clk); dir = d; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    scan_cyc = 0;
    while (busy && !dead && scan_cyc < 64) begin
      scan_cyc++;
      @(negedge clk);
    end
    if (scan_cyc >= 64) chk("scan_timeout", 32'(scan_cyc), 32'd0);
    sd_seen = step_done;
  endtask

  initial begin
    do_reset();
    chk("rst_h0x", 32'(snake_pos[0].x), 32'd400);
    chk("rst_h0y", 32'(snake_pos[0].y), 32'd300);
    chk("rst_s3x", 32'(snake_pos[3].x), 32'd340);
    chk("rst_s4x", 32'(snake_pos[4].x), 32'd0);
    chk("rst_len", 32'(length), 32'd4);
    chk("rst_mask", mask, 32'h0000_000F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dead", 32'(dead), 32'd0);
    chk("rst_sd", 32'(step_done), 32'd0);

    // Plain right move
    run_tick(2'b01, cyc, sd);
    chk("r_h0x", 32'(snake_pos[0].x), 32'd420);
    chk("r_h0y", 32'(snake_pos[0].y), 32'd300);
    chk("r_s3x", 32'(snake_pos[3].x), 32'd360);
    chk("r_scan", 32'(cyc), 32'd3);
    chk("r_sd", 32'(sd), 32'd1);
    @(negedge clk);
    chk("r_sd_pulse", 32'(step_done), 32'd0);

    // Reverse request is ignored
    do_reset();
    run_tick(2'b11, cyc, sd);
    chk("rev_h0x", 32'(snake_pos[0].x), 32'd420);
    chk("rev_h0y", 32'(snake_pos[0].y), 32'd300);
    chk("rev_sd", 32'(sd), 32'd1);

    // Grow then move, then self-collision via up, left, down
    do_reset();
    @(negedge clk); grow = 1'b1;
    @(negedge clk); grow = 1'b0;
    run_tick(2'b01, cyc, sd);
    chk("g_len", 32'(length), 32'd5);
    chk("g_mask", mask, 32'h0000_001F);
    chk("g_s4x", 32'(snake_pos[4].x), 32'd340);
    chk("g_s4y", 32'(snake_pos[4].y), 32'd300);
    chk("g_scan", 32'(cyc), 32'd4);
    run_tick(2'b00, cyc, sd);
    chk("up_h0y", 32'(snake_pos[0].y), 32'd280);
    chk("up_sd", 32'(sd), 32'd1);
    run_tick(2'b11, cyc, sd);
    chk("lf_h0x", 32'(snake_pos[0].x), 32'd400);
    run_tick(2'b10, cyc, sd);
    chk("col_h0x", 32'(snake_pos[0].x), 32'd400);
    chk("col_h0y", 32'(snake_pos[0].y), 32'd300);
    chk("col_s4x", 32'(snake_pos[4].x), 32'd400);
    chk("col_s4y", 32'(snake_pos[4].y), 32'd300);
    chk("col_scan", 32'(cyc), 32'd4);
    chk("col_dead", 32'(dead), 32'd1);
    chk("col_busy", 32'(busy), 32'd1);
    chk("col_sd", 32'(sd), 32'd0);

    // Grow and tick on the same cycle count toward that move
    do_reset();
    @(negedge clk); dir = 2'b01; tick = 1'b1; grow = 1'b1;
    @(negedge clk); tick = 1'b0; grow = 1'b0;
    chk("gt_len", 32'(length), 32'd5);
    chk("gt_s4x", 32'(snake_pos[4].x), 32'd340);

    // Right wall
    do_reset();
    for (int k = 0; k < 19; k++) run_tick(2'b01, cyc, sd);
    chk("w_h0x_780", 32'(snake_pos[0].x), 32'd780);
    chk("w_alive", 32'(dead), 32'd0);
    run_tick(2'b01, cyc, sd);
    chk("w_dead", 32'(dead), 32'd1);
    chk("w_busy", 32'(busy), 32'd1);
    chk("w_h0x", 32'(snake_pos[0].x), 32'd780);
    chk("w_h0y", 32'(snake_pos[0].y), 32'd300);
    @(negedge clk); dir = 2'b00; tick = 1'b1; grow = 1'b1;
    @(negedge clk); tick = 1'b0; grow = 1'b0;
    @(negedge clk); dir = 2'b00; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("w_hold_x", 32'(snake_pos[0].x), 32'd780);
    chk("w_hold_y", 32'(snake_pos[0].y), 32'd300);
    chk("w_hold_len", 32'(length), 32'd4);
    chk("w_hold_dead", 32'(dead), 32'd1);

    // Reset in the middle of a scan
    do_reset();
    @(negedge clk); dir = 2'b01; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("ms_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("ms_h0x", 32'(snake_pos[0].x), 32'd400);
    chk("ms_s1x", 32'(snake_pos[1].x), 32'd380);
    chk("ms_busy0", 32'(busy), 32'd0);
    chk("ms_len", 32'(length), 32'd4);
    run_tick(2'b01, cyc, sd);
    chk("ms_tick_h0x", 32'(snake_pos[0].x), 32'd420);
    chk("ms_tick_scan", 32'(cyc), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
